host_frame_tx: RTL and testbench

HOST_FRAME_TX -- requirements
Module: host_frame_tx

---
 rtl/definitions_pkg.sv | 6 +
 rtl/host_baud_gen.sv | 17 +
 rtl/host_frame_tx.sv | 118 +++++++++++
 tb/tb_host_frame_tx.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/definitions_pkg.sv
// definitions_pkg: shared widths, baud default and FSM state encoding for the host frame transmitter.
package definitions_pkg;
  localparam int FIFO_WIDTH = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;
  typedef enum logic [2:0] {IDLE, WAIT_PIX, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT} state_t;
endpackage

// File: rtl/host_baud_gen.sv
// host_baud_gen: one-cycle bit_tick every CLKS_PER_BIT cycles, restarted by clr.
module host_baud_gen
  import definitions_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rstN,
  input  logic clr,
  output logic bit_tick
);
  localparam int W = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign bit_tick = cnt_q == W'(CLKS_PER_BIT - 1);
  always_comb cnt_d = (clr || bit_tick) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) cnt_q <= rstN ? '0 : cnt_d;
endmodule

// File: rtl/host_frame_tx.sv
// host_frame_tx: sends FRAME_PIXELS bytes as UART characters (8N1, or 8E1 when HOST_TX_PARITY_EN is defined).
module host_frame_tx
  import definitions_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FRAME_PIXELS = 4096
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  start,
  input  logic [FIFO_WIDTH-1:0] pix_data,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           pix_count
);
  state_t state_q, state_d;
  logic [FIFO_WIDTH-1:0] data_q, data_d;
  logic [2:0] idx_q, idx_d;
  logic tx_q, tx_d, pix_ready_q, pix_ready_d, busy_q, busy_d, frame_done_q, frame_done_d;
  logic [15:0] pix_count_q, pix_count_d, count_next;
  logic accept, bit_tick;
  assign accept = pix_ready_q && pix_valid;
  assign count_next = pix_count_q + 16'd1;
  host_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk), .rstN(rstN), .clr(accept), .bit_tick(bit_tick)
  );
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    idx_d = idx_q;
    tx_d = tx_q;
    pix_ready_d = pix_ready_q;
    busy_d = busy_q;
    frame_done_d = 1'b0;
    pix_count_d = pix_count_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (start) begin
          state_d = WAIT_PIX;
          pix_count_d = '0;
          busy_d = 1'b1;
          pix_ready_d = 1'b1;
        end
      end
      WAIT_PIX: if (accept) begin
        state_d = START_BIT;
        data_d = pix_data;
        idx_d = '0;
        tx_d = 1'b0;
        pix_ready_d = 1'b0;
      end
      START_BIT: if (bit_tick) begin
        state_d = DATA_BITS;
        tx_d = data_q[0];
      end
      DATA_BITS: if (bit_tick) begin
        if (idx_q == 3'd7) begin
`ifdef HOST_TX_PARITY_EN
          state_d = PARITY_BIT;
          tx_d = ^data_q;
`else
          state_d = STOP_BIT;
          tx_d = 1'b1;
`endif
        end else begin
          idx_d = idx_q + 3'd1;
          tx_d = data_q[idx_q + 3'd1];
        end
      end
      PARITY_BIT: if (bit_tick) begin
        state_d = STOP_BIT;
        tx_d = 1'b1;
      end
      STOP_BIT: if (bit_tick) begin
        pix_count_d = count_next;
        if (count_next == 16'(FRAME_PIXELS)) begin
          state_d = IDLE;
          busy_d = 1'b0;
          frame_done_d = 1'b1;
        end else begin
          state_d = WAIT_PIX;
          pix_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rstN) begin
      state_q <= IDLE;
      data_q <= '0;
      idx_q <= '0;
      tx_q <= 1'b1;
      pix_ready_q <= 1'b0;
      busy_q <= 1'b0;
      frame_done_q <= 1'b0;
      pix_count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      idx_q <= idx_d;
      tx_q <= tx_d;
      pix_ready_q <= pix_ready_d;
      busy_q <= busy_d;
      frame_done_q <= frame_done_d;
      pix_count_q <= pix_count_d;
    end
  end
  assign tx = tx_q;
  assign pix_ready = pix_ready_q;
  assign busy = busy_q;
  assign frame_done = frame_done_q;
  assign pix_count = pix_count_q;
endmodule

// File: tb/tb_host_frame_tx.sv
// tb_host_frame_tx: randomized frames decoded as a UART line and compared with expected characters.
module tb_host_frame_tx;
  localparam int C = 4;
  localparam int FP = 3;
`ifdef HOST_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 0, rstN = 1, start = 0, pix_valid = 0;
  logic [7:0] pix_data = 0;
  logic pix_ready, tx, busy, frame_done;
  logic [15:0] pix_count;
  int checks = 0, failures = 0;

  host_frame_tx #(.CLKS_PER_BIT(C), .FRAME_PIXELS(FP)) dut (
    .clk(clk), .rstN(rstN), .start(start), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .tx(tx), .busy(busy), .frame_done(frame_done), .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rstN = 1; pix_valid = 1; pix_data = 8'h5A;
    repeat (3) @(negedge clk);
    checks++; if ({tx, pix_ready, busy, frame_done} !== 4'b1000) begin failures++;
      $display("FAIL reset_outputs got tx/rdy/busy/done=%b want 1000", {tx, pix_ready, busy, frame_done}); end
    checks++; if (pix_count !== 16'd0) begin failures++;
      $display("FAIL reset_count got %0d want 0", pix_count); end
    rstN = 0;
    repeat (10) @(negedge clk);
    checks++; if ({tx, pix_ready, busy, pix_count} !== {3'b100, 16'd0}) begin failures++;
      $display("FAIL idle_ignores_valid got tx=%b rdy=%b busy=%b cnt=%0d want 1 0 0 0", tx, pix_ready, busy, pix_count); end
    pix_valid = 0;
  endtask

  // Runs one frame; the line is recorded per cycle and decoded afterwards as UART characters.
  task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input int wh_idx, input int wh_len, input bit pulse_start, input string nm);
    logic [7:0] bytes [3];
    logic txs [$];
    logic e;
    int k, wh, wh_bad, busy_bad, done_cnt, cyc, since2, i, gap, exp_gap, bad, bi, idle_bad;
    bit done;
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
    k = 0; wh = 0; wh_bad = 0; busy_bad = 0; done_cnt = 0; cyc = 0; since2 = 0; done = 0; idle_bad = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    checks++; if (busy !== 1'b1 || pix_count !== 16'd0 || pix_ready !== 1'b1) begin failures++;
      $display("FAIL %s start_accept got busy=%b cnt=%0d rdy=%b want 1 0 1", nm, busy, pix_count, pix_ready); end
    while (!done && cyc < 2000) begin
      txs.push_back(tx);
      if (frame_done === 1'b1) begin done_cnt++; done = 1; end
      if (!done && busy !== 1'b1) busy_bad++;
      pix_valid = 0;
      if (k < 3) begin
        if (k == wh_idx && wh < wh_len && (pix_ready === 1'b1 || wh > 0)) begin
          wh++;
          if (pix_ready !== 1'b1 || tx !== 1'b1 || pix_count !== 16'(k)) wh_bad++;
        end else pix_valid = 1;
      end
      if (pix_valid) pix_data = bytes[k]; else pix_data = 8'($urandom);
      if (pix_valid && pix_ready === 1'b1) k++;
      if (k == 2) since2++;
      start = pulse_start && k == 2 && since2 == 10;
      @(negedge clk); cyc++;
    end
    pix_valid = 0; start = 0;
    checks++; if (!done) begin failures++;
      $display("FAIL %s frame_timeout got no frame_done within %0d cycles want one", nm, cyc); end
    repeat (60) begin
      if (frame_done === 1'b1) done_cnt++;
      if (tx !== 1'b1 || busy !== 1'b0) idle_bad++;
      @(negedge clk);
    end
    checks++; if (done_cnt !== 1) begin failures++;
      $display("FAIL %s frame_done_pulses got %0d want 1", nm, done_cnt); end
    checks++; if (busy_bad !== 0) begin failures++;
      $display("FAIL %s busy_during_frame got %0d low cycles want 0", nm, busy_bad); end
    checks++; if (idle_bad !== 0) begin failures++;
      $display("FAIL %s idle_after_frame got %0d bad cycles want 0", nm, idle_bad); end
    checks++; if (pix_count !== 16'(FP)) begin failures++;
      $display("FAIL %s final_count got %0d want %0d", nm, pix_count, FP); end
    if (wh_idx >= 0) begin
      checks++; if (wh_bad !== 0 || wh !== wh_len) begin failures++;
        $display("FAIL %s withhold got bad=%0d cycles=%0d want 0 %0d", nm, wh_bad, wh, wh_len); end
    end
    i = 0;
    for (int j = 0; j < 3; j++) begin
      gap = 0; bad = 0;
      while (i < txs.size() && txs[i] === 1'b1) begin gap++; i++; end
      exp_gap = 1 + ((j == wh_idx) ? wh_len : 0);
      checks++; if (gap !== exp_gap) begin failures++;
        $display("FAIL %s gap%0d got %0d idle cycles want %0d", nm, j, gap, exp_gap); end
      for (int p = 0; p < NB * C; p++) begin
        bi = p / C;
        if (bi == 0) e = 1'b0;
        else if (bi <= 8) e = bytes[j][bi-1];
        else if (bi == 9 && NB == 11) e = ^bytes[j];
        else e = 1'b1;
        if (i >= txs.size() || txs[i] !== e) bad++;
        i++;
      end
      checks++; if (bad !== 0) begin failures++;
        $display("FAIL %s char%0d byte=%h got %0d wrong line cycles want 0", nm, j, bytes[j], bad); end
    end
  endtask

  task automatic test_known_frames();
    run_frame(8'hA5, 8'h00, 8'hFF, -1, 0, 0, "a5_00_ff");
    run_frame(8'h00, 8'hFF, 8'h3C, -1, 0, 0, "back_to_back");
    run_frame(8'h07, 8'h03, 8'h80, -1, 0, 0, "parity_pair");
  endtask

  task automatic test_withhold();
    run_frame(8'h11, 8'h22, 8'h33, 1, 20, 0, "withhold20");
    run_frame(8'h81, 8'h42, 8'h24, 0, 7, 0, "withhold_first");
  endtask

  task automatic test_start_ignored();
    run_frame(8'hC3, 8'h96, 8'h69, -1, 0, 1, "start_while_busy");
  endtask

  task automatic test_reset_mid();
    int c;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0; pix_valid = 1; pix_data = 8'h5A;
    for (c = 0; c < 400 && pix_count !== 16'd1; c++) @(negedge clk);
    checks++; if (pix_count !== 16'd1) begin failures++;
      $display("FAIL rst_mid first_char got cnt=%0d want 1", pix_count); end
    for (c = 0; c < 400 && tx !== 1'b0; c++) @(negedge clk);
    repeat (4 * C + 1) @(negedge clk);
    rstN = 1; pix_valid = 0;
    @(negedge clk); rstN = 0;
    checks++; if ({tx, busy, pix_ready, frame_done} !== 4'b1000 || pix_count !== 16'd0) begin failures++;
      $display("FAIL rst_mid after_reset got tx=%b busy=%b rdy=%b done=%b cnt=%0d want 1 0 0 0 0",
               tx, busy, pix_ready, frame_done, pix_count); end
    c = 0;
    repeat (40) begin if (tx !== 1'b1 || busy !== 1'b0) c++; @(negedge clk); end
    checks++; if (c !== 0) begin failures++;
      $display("FAIL rst_mid quiet_line got %0d active cycles want 0", c); end
    run_frame(8'($urandom), 8'($urandom), 8'($urandom), -1, 0, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++)
      run_frame(8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)) - 1,
                int'($urandom_range(1, 25)), 1'($urandom), "random");
  endtask

  initial begin
    test_reset();
    test_known_frames();
    test_withhold();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
